iterative_shifter: RTL and testbench

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 23 ++
 rtl/iterative_shifter.sv | 92 +++++++++
 tb/tb_iterative_shifter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: operation modes and FSM states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL  = 2'b00,
        SRA  = 2'b01,
        ROR  = 2'b10,
        RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage : shifter_pkg

// File: rtl/shift_step.sv
// Single 1-bit shift/rotate step, selected by mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] data_o
);

    // One-position shift: left with zero fill, arithmetic right, or rotate right.
    always_comb begin
        data_o = data_i;
        unique case (mode_i)
            SLL:     data_o = {data_i[WIDTH-2:0], 1'b0};
            SRA:     data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            ROR:     data_o = {data_i[0], data_i[WIDTH-1:1]};
            default: data_o = data_i;
        endcase
    end

endmodule : shift_step

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: applies one 1-bit step per clock until the captured
// shift count is exhausted, then presents the result for a single done cycle.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [CNT_W-1:0] Shift_Val,
    input  logic [1:0]       Mode,
    output logic [WIDTH-1:0] Shift_Out,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;

    logic [WIDTH-1:0] step_d;
    mode_e            mode_in;

    assign mode_in = mode_e'(Mode);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (work_q),
        .mode_i (mode_q),
        .data_o (step_d)
    );

    // FSM, work/count registers and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= SLL;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        work_q <= Shift_In;
                        cnt_q  <= Shift_Val;
                        mode_q <= mode_in;
                        if (Shift_Val != '0 && mode_in != RSVD) begin
                            state_q <= SHIFT;
                        end else begin
                            // Zero count or reserved mode: pass operand straight to the result.
                            state_q  <= DONE;
                            result_q <= Shift_In;
                            err_q    <= (mode_in == RSVD);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= step_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q  <= DONE;
                        result_q <= step_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Shift_Out = result_q;
    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign err       = err_q;

endmodule : iterative_shifter

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter with a behavioural reference model.
module tb_iterative_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_Val;
    logic [1:0]  Mode;
    logic [15:0] Shift_Out;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    iterative_shifter #(
        .WIDTH (16),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Shift_In  (Shift_In),
        .Shift_Val (Shift_Val),
        .Mode      (Mode),
        .Shift_Out (Shift_Out),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-amount shift computed in one go from the operation definition.
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input int n, input logic [1:0] m);
        logic signed [15:0] sx;
        sx = x;
        case (m)
            2'b00:   return x << n;
            2'b01:   return 16'(sx >>> n);
            2'b10:   return (n == 0) ? x : ((x >> n) | (x << (16 - n)));
            default: return x;
        endcase
    endfunction

    // Posedges from accept edge up to and including the one that raises done.
    function automatic int ref_lat(input int n, input logic [1:0] m);
        return (n == 0 || m == 2'b11) ? 1 : n + 1;
    endfunction

    // Issue one operation, scramble inputs while it runs, wait (bounded) for done.
    task automatic do_op(input logic [15:0] x, input logic [3:0] n, input logic [1:0] m,
                         output int lat, output logic [15:0] out, output logic e,
                         output logic stable);
        logic [15:0] prev;
        prev = Shift_Out;
        @(negedge clk);
        start = 1'b1; Shift_In = x; Shift_Val = n; Mode = m;
        @(negedge clk);
        start = 1'b0;
        Shift_In = 16'($urandom); Shift_Val = 4'($urandom); Mode = 2'($urandom);
        lat = 1;
        stable = 1'b1;
        while (!done && lat < 40) begin
            if (Shift_Out !== prev) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        out = Shift_Out;
        e   = err;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; Shift_In = '0; Shift_Val = '0; Mode = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h0000 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got out=%h done=%b err=%b busy=%b ready=%b, expected out=0000 done=0 err=0 busy=0 ready=1",
                     Shift_Out, done, err, busy, ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] xs [5] = '{16'h0001, 16'h8000, 16'h0001, 16'hA5A5, 16'hA5A5};
        logic [3:0]  ns [5] = '{4'd4, 4'd15, 4'd1, 4'd0, 4'd5};
        logic [1:0]  ms [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
        logic [15:0] ex [5] = '{16'h0010, 16'hFFFF, 16'h8000, 16'hA5A5, 16'hA5A5};
        int          el [5] = '{5, 16, 2, 1, 1};
        logic        ee [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [15:0] out; logic e; logic st;
        for (int i = 0; i < 5; i++) begin
            do_op(xs[i], ns[i], ms[i], lat, out, e, st);
            checks++;
            if (out !== ex[i] || lat != el[i] || e !== ee[i] || st !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d: got out=%h lat=%0d err=%b stable=%b, expected out=%h lat=%0d err=%b stable=1",
                         i, out, lat, e, st, ex[i], el[i], ee[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || err !== 1'b0 || Shift_Out !== ex[i]) begin
                errors++;
                $display("FAIL done_pulse_%0d: got done=%b err=%b out=%h, expected done=0 err=0 out=%h",
                         i, done, err, Shift_Out, ex[i]);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back;
        logic [15:0] exp1, exp2;
        int lat;
        exp1 = ref_shift(16'h1234, 6, 2'b00);
        exp2 = ref_shift(16'h00F0, 2, 2'b01);
        @(negedge clk);
        start = 1'b1; Shift_In = 16'h1234; Shift_Val = 4'd6; Mode = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; Shift_In = 16'hFFFF; Shift_Val = 4'd1; Mode = 2'b10;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_mid: got busy=%b ready=%b, expected busy=1 ready=0", busy, ready);
        end
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || Shift_Out !== exp1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: got out=%h lat=%0d err=%b, expected out=%h lat=4 err=0", Shift_Out, lat, err, exp1);
        end
        start = 1'b1; Shift_In = 16'h00F0; Shift_Val = 4'd2; Mode = 2'b01;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || Shift_Out !== exp1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b out=%h, expected busy=1 done=0 out=%h", busy, done, Shift_Out, exp1);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2 || Shift_Out !== exp2) begin
            errors++;
            $display("FAIL b2b_result: got out=%h lat=%0d, expected out=%h lat=2", Shift_Out, lat, exp2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen;
        int lat; logic [15:0] out; logic e; logic st;
        @(negedge clk);
        start = 1'b1; Shift_In = 16'hBEEF; Shift_Val = 4'd8; Mode = 2'b10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1 || Shift_Out !== 16'h0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b ready=%b out=%h done=%b, expected busy=0 ready=1 out=0000 done=0",
                     busy, ready, Shift_Out, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done seen=%b, expected 0", seen);
        end
        do_op(16'h0003, 4'd3, 2'b00, lat, out, e, st);
        checks++;
        if (out !== 16'h0018 || lat != 4 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got out=%h lat=%0d err=%b, expected out=0018 lat=4 err=0", out, lat, e);
        end
    endtask

    task automatic test_random;
        logic [15:0] x, exp; logic [3:0] n; logic [1:0] m;
        int lat; logic [15:0] out; logic e; logic st;
        for (int i = 0; i < 50; i++) begin
            x = 16'($urandom);
            n = 4'($urandom_range(15, 0));
            m = 2'($urandom_range(2, 0));
            exp = ref_shift(x, int'(n), m);
            do_op(x, n, m, lat, out, e, st);
            checks++;
            if (out !== exp || lat != ref_lat(int'(n), m) || e !== 1'b0 || st !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: x=%h n=%0d m=%0d got out=%h lat=%0d err=%b stable=%b, expected out=%h lat=%0d err=0 stable=1",
                         i, x, n, m, out, lat, e, st, exp, ref_lat(int'(n), m));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_iterative_shifter
